// File: rtl/pc_unit.sv
// Program-counter unit at the head of fetch: sequential advance, stall hold,
// prioritised trap/branch/return redirects and a circular return-address stack.
module pc_unit #(
  parameter int unsigned      WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      RAS_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         trap,
  input  logic [WIDTH-1:0]             trap_vec,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_target,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc_out,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign_err,
  output logic                         ras_underflow
);

  localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             mis_q, mis_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] sel_tgt;
  logic [PTR_W-1:0] top_idx;
  logic             ras_op, push, pop, empty;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign pc_inc  = pc_q + STEP;
  assign top_idx = ptr_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);
  assign ras_op  = !stall && !trap;
  assign push    = ras_op && call;
  assign pop     = ras_op && ret;
  assign sel_tgt = trap ? trap_vec : redirect_target;

  // Next-PC selection and RAS bookkeeping; ptr_q points at the next free slot.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    mis_d  = 1'b0;
    unf_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = ptr_q;

    if (trap || redirect) begin
      if ((sel_tgt & ALIGN_MASK) != '0) mis_d = 1'b1;
      else                              pc_d  = sel_tgt;
    end else if (ret && !stall) begin
      pc_d = empty ? pc_inc : ras_q[top_idx];
    end else if (!stall) begin
      pc_d = pc_inc;
    end

    if (trap) begin
      cnt_d = '0;
    end else begin
      if (pop && empty) unf_d = 1'b1;
      if (push && pop && !empty) begin
        // Return-then-call: the popped slot is reused for the new return address.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + PTR_W'(1);
        if (cnt_q != FULL) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ptr_q <= '0;
      mis_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      mis_q <= mis_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset; entries beyond ras_count are never read.
  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= pc_inc;
  end

  assign pc_out        = pc_q;
  assign ras_count     = cnt_q;
  assign misalign_err  = mis_q;
  assign ras_underflow = unf_q;

endmodule
